// File: rtl/flash_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : flash_read_arbiter
// Purpose  : Two-port, fixed-priority arbiter that turns 16-bit word reads
//            into two timed byte reads on a shared 8-bit NOR flash port.
//            Optional macro FLASH_ARB_STARVE_GUARD_EN bounds port-0 bursts.
// Revision : 1.0  initial release
// ============================================================================
module flash_read_arbiter #(
    parameter int WAIT_CYCLES  = 4,
    parameter int MAX_P0_BURST = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0,
    input  logic [21:0] i_addr0,
    input  logic        i_req1,
    input  logic [21:0] i_addr1,
    output logic        o_ack0,
    output logic        o_ack1,
    output logic [15:0] o_rdata,
    output logic        o_busy,
    output logic        o_grant,
    output logic [22:0] o_flash_addr,
    input  logic [7:0]  i_flash_dq,
    output logic        o_flash_ce_n,
    output logic        o_flash_oe_n,
    output logic        o_flash_we_n,
    output logic        o_flash_rst_n,
    output logic        o_flash_wp_n
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BYTE0 = 2'd1,
        S_BYTE1 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [21:0] addr_q, addr_d;
    logic        grant_q, grant_d;
    logic [7:0]  hi_q, hi_d, lo_q, lo_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic [22:0] faddr_q, faddr_d;
    logic        win1;
    logic [21:0] win_addr;

`ifdef FLASH_ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    // Port 1 also wins once port 0 has used up its burst allowance.
    always_comb begin
        win1 = i_req1 && (!i_req0 || (starve_q == 4'(MAX_P0_BURST)));
    end

    always_comb begin
        starve_d = starve_q;
        if (state_q == S_IDLE) begin
            if (!i_req1 || win1) begin
                starve_d = 4'd0;
            end else if (i_req0) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    always_comb begin
        win1 = i_req1 && !i_req0;
    end
`endif

    assign win_addr = win1 ? i_addr1 : i_addr0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        grant_d = grant_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        faddr_d = faddr_q;
        case (state_q)
            S_IDLE: begin
                if (i_req0 || i_req1) begin
                    grant_d = win1;
                    addr_d  = win_addr;
                    faddr_d = {win_addr, 1'b0};
                    cnt_d   = C_WAIT_LOAD;
                    state_d = S_BYTE0;
                end
            end
            S_BYTE0: begin
                if (cnt_q == 4'd0) begin
                    hi_d    = i_flash_dq;
                    faddr_d = {addr_q, 1'b1};
                    cnt_d   = C_WAIT_LOAD;
                    state_d = S_BYTE1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_BYTE1: begin
                if (cnt_q == 4'd0) begin
                    lo_d    = i_flash_dq;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                rdata_d = {hi_q, lo_q};
                ack0_d  = !grant_q;
                ack1_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 22'd0;
            grant_q <= 1'b0;
            hi_q    <= 8'd0;
            lo_q    <= 8'd0;
            rdata_q <= 16'd0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            faddr_q <= 23'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            grant_q <= grant_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            faddr_q <= faddr_d;
        end
    end

    // Flash is only selected while a byte address is being presented.
    assign o_flash_ce_n  = !((state_q == S_BYTE0) || (state_q == S_BYTE1));
    assign o_flash_oe_n  = o_flash_ce_n;
    assign o_flash_we_n  = 1'b1;
    assign o_flash_rst_n = 1'b1;
    assign o_flash_wp_n  = 1'b0;
    assign o_flash_addr  = faddr_q;
    assign o_ack0        = ack0_q;
    assign o_ack1        = ack1_q;
    assign o_rdata       = rdata_q;
    assign o_grant       = grant_q;
    assign o_busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_flash_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_read_arbiter
// Purpose  : Directed self-checking bench for flash_read_arbiter
//            (WAIT_CYCLES=4 main instance, WAIT_CYCLES=1 second instance).
// Revision : 1.0  initial release
// ============================================================================
module tb_flash_read_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req0 = 1'b0, req1 = 1'b0;
    logic [21:0] addr0 = '0, addr1 = '0;
    logic        ack0, ack1, busy, grant, ce_n, oe_n, we_n, frst_n, wp_n;
    logic [15:0] rdata;
    logic [22:0] faddr;
    logic [7:0]  dq;

    logic        req0_b = 1'b0, req1_b = 1'b0;
    logic [21:0] addr0_b = '0, addr1_b = '0;
    logic        ack0_b, ack1_b, busy_b, grant_b, ce_n_b, oe_n_b, we_n_b, frst_n_b, wp_n_b;
    logic [15:0] rdata_b;
    logic [22:0] faddr_b;
    logic [7:0]  dq_b;

    // Flash model: each byte location holds the low 8 bits of its own address.
    assign dq   = oe_n   ? 8'hFF : faddr[7:0];
    assign dq_b = oe_n_b ? 8'hFF : faddr_b[7:0];

    always #5 clk = ~clk;

    flash_read_arbiter #(.WAIT_CYCLES(4), .MAX_P0_BURST(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_addr0(addr0), .i_req1(req1), .i_addr1(addr1),
        .o_ack0(ack0), .o_ack1(ack1), .o_rdata(rdata), .o_busy(busy), .o_grant(grant),
        .o_flash_addr(faddr), .i_flash_dq(dq),
        .o_flash_ce_n(ce_n), .o_flash_oe_n(oe_n), .o_flash_we_n(we_n),
        .o_flash_rst_n(frst_n), .o_flash_wp_n(wp_n)
    );

    flash_read_arbiter #(.WAIT_CYCLES(1), .MAX_P0_BURST(8)) dut_w1 (
        .i_clk(clk), .i_rst(rst),
        .i_req0(req0_b), .i_addr0(addr0_b), .i_req1(req1_b), .i_addr1(addr1_b),
        .o_ack0(ack0_b), .o_ack1(ack1_b), .o_rdata(rdata_b), .o_busy(busy_b), .o_grant(grant_b),
        .o_flash_addr(faddr_b), .i_flash_dq(dq_b),
        .o_flash_ce_n(ce_n_b), .o_flash_oe_n(oe_n_b), .o_flash_we_n(we_n_b),
        .o_flash_rst_n(frst_n_b), .o_flash_wp_n(wp_n_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Observations gathered by run(); cycle numbers count edges from 0.
    int          first0, first1, cnt0, cnt1, overlap, p0_before;
    logic [15:0] rd0, rd1;
    logic        g0, g1;
    logic [22:0] fa_hist [0:31];
    logic        ce_hist [0:31];

    task automatic run(input bit sel, input int n, input bit auto_drop, input int drop1_at);
        logic a0, a1;
        first0 = -1; first1 = -1; cnt0 = 0; cnt1 = 0; overlap = 0; p0_before = 0;
        for (int c = 0; c < n; c++) begin
            tick;
            a0 = sel ? ack0_b : ack0;
            a1 = sel ? ack1_b : ack1;
            if (c < 32) begin
                fa_hist[c] = sel ? faddr_b : faddr;
                ce_hist[c] = sel ? ce_n_b : ce_n;
            end
            if (a0 && a1) overlap++;
            if (a0) begin
                if (first0 < 0) begin
                    first0 = c;
                    rd0 = sel ? rdata_b : rdata;
                    g0  = sel ? grant_b : grant;
                end
                cnt0++;
                if (first1 < 0) p0_before++;
                if (auto_drop) req0 = 1'b0;
            end
            if (a1) begin
                if (first1 < 0) begin
                    first1 = c;
                    rd1 = sel ? rdata_b : rdata;
                    g1  = sel ? grant_b : grant;
                end
                cnt1++;
                if (auto_drop) req1 = 1'b0;
            end
            if (c == drop1_at - 1) begin
                req1  = 1'b0;
                addr1 = 22'd0;
            end
        end
    endtask

    initial begin
        repeat (2) tick;
        rst = 1'b0;
        tick;

        // Reset state
        check_eq("rst_ack0", 32'(ack0), 32'h0);
        check_eq("rst_ack1", 32'(ack1), 32'h0);
        check_eq("rst_rdata", 32'(rdata), 32'h0);
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_faddr", 32'(faddr), 32'h0);
        check_eq("rst_ce_oe", 32'({ce_n, oe_n}), 32'h3);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("const_pins", 32'({we_n, frst_n, wp_n}), 32'h6);

        // Single port-0 read
        req0 = 1'b1; addr0 = 22'h000123;
        run(1'b0, 12, 1'b1, -1);
        check_eq("t1_faddr_c0", 32'(fa_hist[0]), 32'h246);
        check_eq("t1_ce_c0", 32'(ce_hist[0]), 32'h0);
        check_eq("t1_faddr_c3", 32'(fa_hist[3]), 32'h246);
        check_eq("t1_faddr_c4", 32'(fa_hist[4]), 32'h247);
        check_eq("t1_faddr_c7", 32'(fa_hist[7]), 32'h247);
        check_eq("t1_ack0_cyc", 32'(first0), 32'd9);
        check_eq("t1_rdata", 32'(rd0), 32'h4647);
        check_eq("t1_ack1_none", 32'(cnt1), 32'd0);
        check_eq("t1_faddr_hold", 32'(fa_hist[11]), 32'h247);
        check_eq("t1_idle_busy", 32'(busy), 32'h0);
        check_eq("t1_idle_ce", 32'(ce_n), 32'h1);

        // Simultaneous requests: port 0 first, then port 1
        req0 = 1'b1; addr0 = 22'h000010;
        req1 = 1'b1; addr1 = 22'h000055;
        run(1'b0, 24, 1'b1, -1);
        check_eq("t2_ack0_cyc", 32'(first0), 32'd9);
        check_eq("t2_ack1_cyc", 32'(first1), 32'd19);
        check_eq("t2_grant0", 32'(g0), 32'h0);
        check_eq("t2_grant1", 32'(g1), 32'h1);
        check_eq("t2_overlap", 32'(overlap), 32'd0);
        check_eq("t2_rdata0", 32'(rd0), 32'h2021);
        check_eq("t2_rdata1", 32'(rd1), 32'hAAAB);

        // Port 1 withdraws (and changes its address) mid-transfer
        req1 = 1'b1; addr1 = 22'h00007F;
        run(1'b0, 14, 1'b1, 3);
        check_eq("t3_ack1_cyc", 32'(first1), 32'd9);
        check_eq("t3_rdata", 32'(rd1), 32'hFEFF);
        check_eq("t3_ack0_none", 32'(cnt0), 32'd0);
        check_eq("t3_idle_busy", 32'(busy), 32'h0);
        check_eq("t3_idle_ce", 32'(ce_n), 32'h1);

        // Reset during BYTE1
        req0 = 1'b1; addr0 = 22'h000100;
        run(1'b0, 5, 1'b1, -1);
        check_eq("t4_pre_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check_eq("t4_rst_ack0", 32'(ack0), 32'h0);
        check_eq("t4_rst_rdata", 32'(rdata), 32'h0);
        check_eq("t4_rst_ce", 32'(ce_n), 32'h1);
        check_eq("t4_rst_busy", 32'(busy), 32'h0);
        req0 = 1'b0;
        repeat (2) tick;
        rst = 1'b0;
        run(1'b0, 12, 1'b1, -1);
        check_eq("t4_no_ack", 32'(cnt0 + cnt1), 32'd0);
        req0 = 1'b1; addr0 = 22'h0000A5;
        run(1'b0, 12, 1'b1, -1);
        check_eq("t4_after_ack", 32'(first0), 32'd9);
        check_eq("t4_after_rdata", 32'(rd0), 32'h4A4B);

        // Both ports held high continuously
        req0 = 1'b1; addr0 = 22'h000001;
        req1 = 1'b1; addr1 = 22'h000002;
        run(1'b0, 150, 1'b0, -1);
        req0 = 1'b0; req1 = 1'b0;
`ifdef FLASH_ARB_STARVE_GUARD_EN
        check_eq("t5_p0_burst", 32'(p0_before), 32'd8);
        check_eq("t5_ack1_cyc", 32'(first1), 32'd89);
        check_eq("t5_rdata1", 32'(rd1), 32'h0405);
`else
        check_eq("t5_ack1_none", 32'(cnt1), 32'd0);
        check_eq("t5_ack0_cnt", 32'(cnt0), 32'd15);
`endif
        check_eq("t5_overlap", 32'(overlap), 32'd0);
        repeat (2) tick;

        // WAIT_CYCLES=1 instance, back-to-back port-0 reads
        req0_b = 1'b1; addr0_b = 22'h0000C3;
        run(1'b1, 12, 1'b0, -1);
        req0_b = 1'b0;
        check_eq("t6_ack0_cyc", 32'(first0), 32'd3);
        check_eq("t6_ack0_cnt", 32'(cnt0), 32'd3);
        check_eq("t6_rdata", 32'(rd0), 32'h8687);
        check_eq("t6_faddr_c1", 32'(fa_hist[1]), 32'h187);
        tick;
        check_eq("t6_idle_busy", 32'(busy_b), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
Shares the single 8-bit parallel NOR flash read port between two requesters: port 0 is the display frame fetcher and port 1 is the auxiliary loader (asset/boss-screen prefetch). It accepts 16-bit word requests, sequences two timed byte reads (high byte first), and returns the assembled word with a one-cycle ack. It owns all flash control pins and sits between the requesters and the top-level flash pads.

Parameters:
WAIT_CYCLES, 4, clocks each byte address is held before dq is sampled (1..15)
MAX_P0_BURST, 8, consecutive port-0 grants allowed while port 1 waits (starvation guard only)

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous reset, active-high
i_req0  input  1  port 0 request; hold high with i_addr0 stable until o_ack0
i_addr0  input  22  port 0 word address
i_req1  input  1  port 1 request; same rules as port 0
i_addr1  input  22  port 1 word address
o_ack0  output  1  one-cycle pulse; o_rdata is valid for port 0
o_ack1  output  1  one-cycle pulse; o_rdata is valid for port 1
o_rdata  output  16  {byte0, byte1}; held until the next ack
o_busy  output  1  high in any state other than IDLE
o_grant  output  1  port that owns the current or last transfer
o_flash_addr  output  23  flash byte address
i_flash_dq  input  8  flash data bus
o_flash_ce_n, o_flash_oe_n  output  1 each  low during BYTE0/BYTE1, high otherwise
o_flash_we_n, o_flash_rst_n  output  1 each  constant 1
o_flash_wp_n  output  1  constant 0

Behaviour:
- Reset (async, i_rst=1):
  - All registers cleared; state IDLE.
  - Acks 0, o_rdata 0, o_grant 0, o_flash_addr 0, ce_n/oe_n 1.
  - Reset mid-transfer aborts the transfer with no ack.
- States:
  - IDLE: arbitrate. If any req is high, latch the winner's address and winner id, then go to BYTE0.
  - BYTE0: o_flash_addr = {addr,1'b0}. Hold for WAIT_CYCLES cycles. On the last cycle capture i_flash_dq into the high byte, then go to BYTE1.
  - BYTE1: o_flash_addr = {addr,1'b1}. Hold for WAIT_CYCLES cycles. On the last cycle capture i_flash_dq into the low byte, then go to DONE.
  - DONE: update o_rdata, pulse the winner's ack for 1 cycle, return to IDLE.
- Latency: req high at edge k in IDLE gives ack high for the cycle starting at edge k+2*WAIT_CYCLES+1. Throughput is one word per 2*WAIT_CYCLES+2 cycles per port (IDLE re-arbitrates).
- Wait counter: 4 bits, loaded with WAIT_CYCLES-1 on state entry, counts down to 0; no wrap.
- Arbitration: fixed priority, port 0 over port 1. Both requesting in the same IDLE cycle means port 0 wins.
- Address and id are latched at grant. Changes to i_addr*/i_req* during a transfer have no effect.
- Request dropped mid-transfer: the transfer completes and the ack still pulses; the requester ignores it.
- Acks never overlap. An ack is never issued to a port that was not granted.
- o_flash_addr holds its last value in IDLE/DONE.

Optional Feature:
FLASH_ARB_STARVE_GUARD_EN
- Defined:
  - A 4-bit counter increments on each port-0 grant made while i_req1 is high.
  - When the counter equals MAX_P0_BURST and i_req1 is high, the next arbitration grants port 1.
  - The counter clears on a port-1 grant, on any IDLE cycle with i_req1 low, and on reset.
- Undefined: strict port-0 priority; port 1 can starve indefinitely.

Test Plan:
- Single port 0, WAIT_CYCLES=4: req0 at cycle 0, addr0=22'h000123, flash model returns byte addr[7:0] (0x46, 0x47) -> o_flash_addr 0x000246 for 4 cycles then 0x000247 for 4 cycles; o_ack0 pulses at cycle 9 with o_rdata=16'h4647.
- Simultaneous: req0 and req1 both rise at cycle 0 -> o_ack0 at cycle 9, o_ack1 at cycle 19, o_grant reads 0 then 1; no overlapping acks.
- Request withdrawal: req1 drops at cycle 3 -> o_ack1 still pulses at cycle 9; next IDLE with no req leaves o_busy=0 and ce_n=1.
- Reset mid-op: i_rst pulsed during BYTE1 -> no ack, o_rdata=0, ce_n=1 immediately; after release a new req0 completes normally.
- Starvation, macro defined, MAX_P0_BURST=8: req0 and req1 both held high -> port 1 is granted after 8 port-0 grants. Macro undefined -> port 1 is never granted while req0 stays high.
- WAIT_CYCLES=1: req0 at cycle 0 -> ack at cycle 3; back-to-back requests return one ack every 4 cycles.
